// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the write sources, the register file and rf_write_arbiter.
// "master" is the control/datapath + register-file side, "slave" is the arbiter.
interface rf_write_arbiter_if #(
    parameter int AW = 2
) ();
    logic          wr1_en;
    logic [3:0]    wr1_dst;
    logic [31:0]   wr1_data;
    logic          wr2_en;
    logic [3:0]    wr2_dst;
    logic [31:0]   wr2_data;
    logic          wr2_ready;
    logic          rf_we;
    logic [3:0]    rf_dst;
    logic [31:0]   rf_data;
    logic [3:0]    rd_src1;
    logic [3:0]    rd_src2;
    logic [31:0]   rf_out1;
    logic [31:0]   rf_out2;
    logic [31:0]   fwd_out1;
    logic [31:0]   fwd_out2;
    logic [AW:0]   q_count;
    logic          overflow;

    modport master (
        output wr1_en, wr1_dst, wr1_data, wr2_en, wr2_dst, wr2_data,
        output rd_src1, rd_src2, rf_out1, rf_out2,
        input  wr2_ready, rf_we, rf_dst, rf_data, fwd_out1, fwd_out2, q_count, overflow
    );

    modport slave (
        input  wr1_en, wr1_dst, wr1_data, wr2_en, wr2_dst, wr2_data,
        input  rd_src1, rd_src2, rf_out1, rf_out2,
        output wr2_ready, rf_we, rf_dst, rf_data, fwd_out1, fwd_out2, q_count, overflow
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port: port 1 writes straight through, port 2 is
// queued and drained on idle cycles, with read forwarding out of the queue.
module rf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               reset,
    rf_write_arbiter_if.slave  bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [3:0]    r_dst   [DEPTH];
    logic [31:0]   r_data  [DEPTH];
    logic          r_valid [DEPTH];
    logic          r_kill  [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_empty;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_we;
    logic [3:0]    w_dst;
    logic [31:0]   w_data;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_fwd1;
    logic [31:0]   w_fwd2;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign w_empty = (r_count == {(AW+1){1'b0}});
    assign w_ready = (r_count != FULL);
    assign w_push  = bus.wr2_en & w_ready;
    assign w_pop   = ~bus.wr1_en & ~w_empty;

    // Write-port mux: port 1 wins, otherwise the queue head (suppressed if killed).
    always_comb begin
        w_we   = 1'b0;
        w_dst  = 4'h0;
        w_data = 32'h0;
        if (bus.wr1_en) begin
            w_we   = 1'b1;
            w_dst  = bus.wr1_dst;
            w_data = bus.wr1_data;
        end else if (!w_empty) begin
            w_we   = ~r_kill[r_rd_ptr];
            w_dst  = r_dst[r_rd_ptr];
            w_data = r_data[r_rd_ptr];
        end else begin
            w_we   = 1'b0;
        end
    end

    // Read forwarding: walk oldest to youngest so the youngest live match is kept.
    always_comb begin
        w_fwd1 = bus.rf_out1;
        w_fwd2 = bus.rf_out2;
        w_idx  = r_rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx  = r_rd_ptr + k[AW-1:0];
            w_fwd1 = (r_valid[w_idx] && !r_kill[w_idx] && (r_dst[w_idx] == bus.rd_src1))
                     ? r_data[w_idx] : w_fwd1;
            w_fwd2 = (r_valid[w_idx] && !r_kill[w_idx] && (r_dst[w_idx] == bus.rd_src2))
                     ? r_data[w_idx] : w_fwd2;
        end
    end

    // Queue storage, kill marking, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dst[i]   <= 4'h0;
                r_data[i]  <= 32'h0;
                r_valid[i] <= 1'b0;
                r_kill[i]  <= 1'b0;
            end
            r_rd_ptr   <= {AW{1'b0}};
            r_wr_ptr   <= {AW{1'b0}};
            r_count    <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            // Port 1 is younger than everything already queued, so it supersedes them.
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.wr1_en && r_valid[i] && (r_dst[i] == bus.wr1_dst)) begin
                    r_kill[i] <= 1'b1;
                end
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_kill[r_rd_ptr]  <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_push) begin
                r_dst[r_wr_ptr]   <= bus.wr2_dst;
                r_data[r_wr_ptr]  <= bus.wr2_data;
                r_valid[r_wr_ptr] <= 1'b1;
                r_kill[r_wr_ptr]  <= 1'b0;
                r_wr_ptr          <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
            if (bus.wr2_en && !w_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.rf_we     = w_we;
    assign bus.rf_dst    = w_dst;
    assign bus.rf_data   = w_data;
    assign bus.wr2_ready = w_ready;
    assign bus.fwd_out1  = w_fwd1;
    assign bus.fwd_out2  = w_fwd2;
    assign bus.q_count   = r_count;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed table-driven bench for rf_write_arbiter with a simple register-file model.
module tb_rf_write_arbiter;
    logic clk;
    logic reset;

    rf_write_arbiter_if #(.AW(2)) bus ();

    rf_write_arbiter #(.DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: distinct initial contents so forwarding is observable.
    logic [31:0] regs [16];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'h1000_0000 + i;
        end else if (bus.rf_we) begin
            regs[bus.rf_dst] <= bus.rf_data;
        end
    end
    assign bus.rf_out1 = regs[bus.rd_src1];
    assign bus.rf_out2 = regs[bus.rd_src2];

    typedef struct {
        logic        wr1_en;  logic [3:0] wr1_dst; logic [31:0] wr1_data;
        logic        wr2_en;  logic [3:0] wr2_dst; logic [31:0] wr2_data;
        logic [3:0]  rd1;     logic [3:0] rd2;
        logic        e_we;    logic [3:0] e_dst;   logic [31:0] e_data;
        logic        e_ready; logic [2:0] e_count; logic        e_ovf;
        logic [31:0] e_fwd1;  logic [31:0] e_fwd2;
    } vec_t;

    vec_t vecs [21];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic w1, input logic [3:0] d1, input logic [31:0] v1,
        input logic w2, input logic [3:0] d2, input logic [31:0] v2,
        input logic [3:0] r1, input logic [3:0] r2,
        input logic we, input logic [3:0] dst, input logic [31:0] dat,
        input logic rdy, input logic [2:0] cnt, input logic ovf,
        input logic [31:0] f1, input logic [31:0] f2);
        vec_t v;
        v.wr1_en = w1; v.wr1_dst = d1; v.wr1_data = v1;
        v.wr2_en = w2; v.wr2_dst = d2; v.wr2_data = v2;
        v.rd1 = r1; v.rd2 = r2;
        v.e_we = we; v.e_dst = dst; v.e_data = dat;
        v.e_ready = rdy; v.e_count = cnt; v.e_ovf = ovf;
        v.e_fwd1 = f1; v.e_fwd2 = f2;
        return v;
    endfunction

    task automatic drive(input logic w1, input logic [3:0] d1, input logic [31:0] v1,
                         input logic w2, input logic [3:0] d2, input logic [31:0] v2);
        bus.wr1_en = w1; bus.wr1_dst = d1; bus.wr1_data = v1;
        bus.wr2_en = w2; bus.wr2_dst = d2; bus.wr2_data = v2;
    endtask

    initial begin
        // wr1 straight through, then a single wr2 forwarded before its pop.
        vecs[0]  = mk(1'b1,4'd3,32'hAAAA0001, 1'b0,4'd0,32'h0, 4'd3,4'd0, 1'b1,4'd3,32'hAAAA0001, 1'b1,3'd0,1'b0, 32'h10000003,32'h10000000);
        vecs[1]  = mk(1'b0,4'd0,32'h0, 1'b1,4'd5,32'h55, 4'd3,4'd5, 1'b0,4'd0,32'h0, 1'b1,3'd0,1'b0, 32'hAAAA0001,32'h10000005);
        vecs[2]  = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd5,4'd3, 1'b1,4'd5,32'h55, 1'b1,3'd1,1'b0, 32'h55,32'hAAAA0001);
        vecs[3]  = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd5,4'd0, 1'b0,4'd0,32'h0, 1'b1,3'd0,1'b0, 32'h55,32'h10000000);
        // Fill the queue behind a busy port 1, overflow on the fifth push.
        vecs[4]  = mk(1'b1,4'd8,32'h80, 1'b1,4'd1,32'h201, 4'd1,4'd8, 1'b1,4'd8,32'h80, 1'b1,3'd0,1'b0, 32'h10000001,32'h10000008);
        vecs[5]  = mk(1'b1,4'd8,32'h81, 1'b1,4'd2,32'h202, 4'd1,4'd8, 1'b1,4'd8,32'h81, 1'b1,3'd1,1'b0, 32'h201,32'h80);
        vecs[6]  = mk(1'b1,4'd8,32'h82, 1'b1,4'd3,32'h203, 4'd2,4'd1, 1'b1,4'd8,32'h82, 1'b1,3'd2,1'b0, 32'h202,32'h201);
        vecs[7]  = mk(1'b1,4'd8,32'h83, 1'b1,4'd4,32'h204, 4'd3,4'd8, 1'b1,4'd8,32'h83, 1'b1,3'd3,1'b0, 32'h203,32'h82);
        vecs[8]  = mk(1'b1,4'd8,32'h84, 1'b1,4'd5,32'h205, 4'd4,4'd5, 1'b1,4'd8,32'h84, 1'b0,3'd4,1'b0, 32'h204,32'h55);
        vecs[9]  = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd1,4'd4, 1'b1,4'd1,32'h201, 1'b0,3'd4,1'b1, 32'h201,32'h204);
        vecs[10] = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd1,4'd2, 1'b1,4'd2,32'h202, 1'b1,3'd3,1'b1, 32'h201,32'h202);
        vecs[11] = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd3,4'd8, 1'b1,4'd3,32'h203, 1'b1,3'd2,1'b1, 32'h203,32'h84);
        vecs[12] = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd4,4'd5, 1'b1,4'd4,32'h204, 1'b1,3'd1,1'b1, 32'h204,32'h55);
        // Two entries for dst 7, youngest forwarded, then both killed by wr1.
        vecs[13] = mk(1'b1,4'd9,32'h90, 1'b1,4'd7,32'h11, 4'd9,4'd7, 1'b1,4'd9,32'h90, 1'b1,3'd0,1'b1, 32'h10000009,32'h10000007);
        vecs[14] = mk(1'b1,4'd9,32'h91, 1'b1,4'd7,32'h22, 4'd9,4'd7, 1'b1,4'd9,32'h91, 1'b1,3'd1,1'b1, 32'h90,32'h11);
        vecs[15] = mk(1'b1,4'd7,32'h99, 1'b0,4'd0,32'h0, 4'd9,4'd7, 1'b1,4'd7,32'h99, 1'b1,3'd2,1'b1, 32'h91,32'h22);
        vecs[16] = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd7,4'd7, 1'b0,4'd7,32'h11, 1'b1,3'd2,1'b1, 32'h99,32'h99);
        vecs[17] = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd7,4'd7, 1'b0,4'd7,32'h22, 1'b1,3'd1,1'b1, 32'h99,32'h99);
        // Same-cycle wr1/wr2 to dst 2: the queued value lands last.
        vecs[18] = mk(1'b1,4'd2,32'h10, 1'b1,4'd2,32'h20, 4'd2,4'd7, 1'b1,4'd2,32'h10, 1'b1,3'd0,1'b1, 32'h202,32'h99);
        vecs[19] = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd2,4'd0, 1'b1,4'd2,32'h20, 1'b1,3'd1,1'b1, 32'h20,32'h10000000);
        vecs[20] = mk(1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0, 4'd2,4'd0, 1'b0,4'd0,32'h0, 1'b1,3'd0,1'b1, 32'h20,32'h10000000);

        reset = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        bus.rd_src1 = 4'd6;
        bus.rd_src2 = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_we",    {31'h0, bus.rf_we},     32'h0);
        chk("reset_ready", {31'h0, bus.wr2_ready}, 32'h1);
        chk("reset_count", {29'h0, bus.q_count},   32'h0);
        chk("reset_ovf",   {31'h0, bus.overflow},  32'h0);
        chk("reset_fwd1",  bus.fwd_out1,           32'h10000006);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].wr1_en, vecs[i].wr1_dst, vecs[i].wr1_data,
                  vecs[i].wr2_en, vecs[i].wr2_dst, vecs[i].wr2_data);
            bus.rd_src1 = vecs[i].rd1;
            bus.rd_src2 = vecs[i].rd2;
            #3;
            chk($sformatf("v%0d_we", i),    {31'h0, bus.rf_we},     {31'h0, vecs[i].e_we});
            chk($sformatf("v%0d_dst", i),   {28'h0, bus.rf_dst},    {28'h0, vecs[i].e_dst});
            chk($sformatf("v%0d_data", i),  bus.rf_data,            vecs[i].e_data);
            chk($sformatf("v%0d_ready", i), {31'h0, bus.wr2_ready}, {31'h0, vecs[i].e_ready});
            chk($sformatf("v%0d_count", i), {29'h0, bus.q_count},   {29'h0, vecs[i].e_count});
            chk($sformatf("v%0d_ovf", i),   {31'h0, bus.overflow},  {31'h0, vecs[i].e_ovf});
            chk($sformatf("v%0d_fwd1", i),  bus.fwd_out1,           vecs[i].e_fwd1);
            chk($sformatf("v%0d_fwd2", i),  bus.fwd_out2,           vecs[i].e_fwd2);
            @(posedge clk); #1;
        end

        // Reset in the middle of a three-entry drain.
        drive(1'b1, 4'd10, 32'hA0, 1'b1, 4'd11, 32'hB1);
        @(posedge clk); #1;
        drive(1'b1, 4'd10, 32'hA1, 1'b1, 4'd12, 32'hB2);
        @(posedge clk); #1;
        drive(1'b1, 4'd10, 32'hA2, 1'b1, 4'd13, 32'hB3);
        @(posedge clk); #1;
        drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        bus.rd_src1 = 4'd11;
        bus.rd_src2 = 4'd13;
        #2;
        chk("drain_count", {29'h0, bus.q_count}, 32'h3);
        chk("drain_we",    {31'h0, bus.rf_we},   32'h1);
        chk("drain_dst",   {28'h0, bus.rf_dst},  32'hB);
        chk("drain_fwd2",  bus.fwd_out2,         32'hB3);
        #1 reset = 1'b1;
        #1;
        chk("mid_reset_count", {29'h0, bus.q_count},   32'h0);
        chk("mid_reset_we",    {31'h0, bus.rf_we},     32'h0);
        chk("mid_reset_ready", {31'h0, bus.wr2_ready}, 32'h1);
        chk("mid_reset_ovf",   {31'h0, bus.overflow},  32'h0);
        chk("mid_reset_fwd2",  bus.fwd_out2,           32'h1000000D);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            chk($sformatf("post_reset%0d_we", c),    {31'h0, bus.rf_we},   32'h0);
            chk($sformatf("post_reset%0d_count", c), {29'h0, bus.q_count}, 32'h0);
            @(posedge clk); #1;
        end
        chk("post_reset_r11", bus.fwd_out1, 32'h1000000B);
        chk("post_reset_r13", bus.fwd_out2, 32'h1000000D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two write sources.
- Port 1 is primary: written straight through, never stalled.
- Port 2 is secondary: buffered in a small in-order queue and drained into the write port on cycles when port 1 is idle.
- Supplies read-forwarding so that values still sitting in the queue are visible on register reads. Sits between the multicycle control/datapath and the register file.

Parameters:
- DEPTH, 4, port-2 queue entries; power of two, at least 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears queue and flags.
- wr1_en  in  1  primary write request.
- wr1_dst  in  4  primary destination register.
- wr1_data  in  32  primary write data.
- wr2_en  in  1  secondary write request.
- wr2_dst  in  4  secondary destination register.
- wr2_data  in  32  secondary write data.
- wr2_ready  out  1  queue can accept; equals (count != DEPTH).
- rf_we  out  1  register-file write enable.
- rf_dst  out  4  register-file write address.
- rf_data  out  32  register-file write data.
- rd_src1, rd_src2  in  4 each  read addresses presented to the register file.
- rf_out1, rf_out2  in  32 each  register-file asynchronous read data.
- fwd_out1, fwd_out2  out  32 each  forwarded read data.
- q_count  out  AW+1  occupied entries, including killed ones.
- overflow  out  1  sticky; a port-2 write was dropped.

Behaviour:
- Reset (async, any time, including mid-drain):
  - count, read pointer and write pointer = 0; all entry valid/kill bits = 0; overflow = 0.
  - Outputs after reset: rf_we=0, wr2_ready=1, q_count=0.
  - fwd_outN = rf_outN.
- Write-port mux (combinational):
  - wr1_en=1: rf_we=1, rf_dst=wr1_dst, rf_data=wr1_data. No pop this cycle.
  - wr1_en=0 and queue non-empty: pop the head at the clock edge. rf_we = head not killed; rf_dst/rf_data = head fields.
  - Otherwise: rf_we=0, rf_dst=0, rf_data=0.
- Push:
  - wr2_en & wr2_ready: at the edge, store {dst, data, live} at the write pointer and advance it (wraps modulo DEPTH).
  - wr2_en & !wr2_ready: request dropped, overflow <= 1. A pop in the same cycle does not make room (ready depends on registered count only).
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Ordering / kill rule:
  - Port 1 is younger than every entry already queued.
  - At an edge where wr1_en=1, every queued entry with dst==wr1_dst gets its kill bit set.
  - A port-2 entry pushed in that same cycle is younger than wr1 and is NOT killed.
  - Killed entries are still popped in order but with rf_we=0; they still count in q_count.
- Forwarding (combinational):
  - fwd_outN = data of the youngest live (not killed) queued entry with dst==rd_srcN, else rf_outN.
  - Entries killed this cycle are still forwardable until the edge, consistent with the register file not yet holding wr1_data.
  - wr1 and wr2 values in the current cycle are never forwarded; they become visible next cycle.
- Latency:
  - wr1: in the register file after 1 edge.
  - wr2 with empty queue and wr1 idle next cycle: in the register file 2 edges after the request.
- No special register 0; all 16 addresses are ordinary.

Test Plan:
- Reset, then wr1 (dst 3, 0xAAAA0001) for one cycle -> rf_we=1, rf_dst=3 in that cycle; q_count stays 0.
- wr2 (dst 5, 0x55) with wr1 idle -> next cycle rf_we=1, rf_dst=5, rf_data=0x55. Before the pop, rd_src1=5 gives fwd_out1=0x55 while rf_out1 is stale.
- Hold wr1_en=1 and push 5 wr2 entries (dst 1..5) -> entries 1..4 accepted; wr2_ready=0 after 4; 5th dropped; overflow=1 and stays 1. Release wr1 -> dsts 1,2,3,4 drained in order, one per cycle.
- Queue holds dst 7 (0x11) and dst 7 (0x22); rd_src2=7 -> fwd_out2=0x22 (youngest). Then wr1 dst 7 (0x99) -> both entries killed; during their pops rf_we=0; q_count decrements 2 then 1 then 0.
- Same cycle: wr1 dst 2 (0x10) and wr2 dst 2 (0x20) -> wr1 written first; next idle cycle writes 0x20. Final register 2 = 0x20.
- Assert reset mid-drain with q_count=3 -> immediately q_count=0, rf_we=0, wr2_ready=1, overflow=0. No further writes after release.
